ex_flag_stage: RTL and testbench
================================

Name: ex_flag_stage

Overview:
- Downstream of the 16-bit saturating add/sub unit in the execute stage.
- Registers each ALU result and its overflow bit into a 2-entry elastic buffer with a valid/ready handshake toward the memory stage.
- Maintains the architectural condition-flag register (Z, V, N), updated according to a per-instruction mask.
- Absorbs one cycle of downstream backpressure without dropping results, and supports pipeline flush.

Parameters:
- WIDTH, 16, data width of the result path.
- CNT_W, 16, width of the overflow event counter (used only under OVFL_CNT_EN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream holds a valid ALU result.
- in_ready  output  1  stage can accept an entry this cycle.
- in_result  input  WIDTH  ALU result, saturated or raw.
- in_ovfl  input  1  overflow flag from the ALU.
- in_mem_op  input  1  result is an address; never updates flags.
- in_flag_mask  input  3  {Z,V,N} update enables.
- flush  input  1  drop all buffered entries.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes the head.
- out_result  output  WIDTH  head entry result.
- out_mem_op  output  1  head entry mem_op.
- flags  output  3  {Z,V,N} architectural flags.
- ovfl_count  output  CNT_W  overflow event count (only under OVFL_CNT_EN).

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low (rst_n), all state cleared on assertion.
- Reset values: out_valid=0, in_ready=1, out_result=0, out_mem_op=0, flags=3'b000, ovfl_count=0, buffer occupancy=0.
- Accept: in_valid & in_ready & ~flush.
- Issue: out_valid & out_ready.
- Buffer: 2 entries, FIFO order.
  - in_ready = (occupancy < 2). It is registered-derived and never depends combinationally on out_ready.
  - out_valid = (occupancy > 0).
  - out_result and out_mem_op come from the head entry.
  - Latency from accept to out_valid is 1 cycle (entry written at edge, visible next cycle).
- Simultaneous accept and issue:
  - At occupancy 1: occupancy stays 1; new entry becomes head after the edge.
  - At occupancy 2: no accept (in_ready=0); issue only.
- Empty: out_valid=0. out_result holds its last value and is a don't-care.
- Full: in_ready=0. Upstream must hold in_valid and its data stable.
- Flag update: on accept only, at the same edge, and only if in_mem_op=0.
  - Z <= (in_result==0) if mask[2].
  - V <= in_ovfl if mask[1].
  - N <= in_result[WIDTH-1] if mask[0].
  - Bits not enabled by the mask hold their value.
- Flags reflect the most recently accepted instruction, not the head entry.
- Flush:
  - Synchronous. Occupancy goes to 0 at the next edge and out_valid=0 the following cycle.
  - Flush wins over a simultaneous accept: the incoming entry is dropped and flags are NOT updated.
  - Flags already committed are not rolled back.
  - A simultaneous issue still counts as delivered; downstream sees out_valid during the flush cycle.
- Reset mid-operation: all entries are lost immediately and flags clear; no partial state survives.
- Pointer wrap: the 1-bit read/write pointers wrap modulo 2. The occupancy counter is 2 bits and is never allowed to exceed 2.

Optional Feature:
- Macro: OVFL_CNT_EN.
- Defined:
  - ovfl_count port exists.
  - Increments by 1 on every accept with in_ovfl=1 and in_mem_op=0.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset; flush does not clear it.
- Undefined: the port and counter logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package:
  - FLAG_Z=2, FLAG_V=1, FLAG_N=0 bit indices.
  - 3-bit flag vector typedef.
  - Mask constants: MASK_ALL=3'b111, MASK_NONE=3'b000, MASK_ZN=3'b101.
  - DATA_W=16.
- Sub-module elastic_buf2: a generic 2-entry valid/ready FIFO carrying {result, mem_op}, with flush.
- The flag register and overflow counter stay in the top level.

Test Plan:
- Basic flag update: accept result=16'h0000, ovfl=0, mask=111, out_ready=1 -> flags=3'b100 the next cycle; out_valid=1 with out_result=0x0000 one cycle after accept.
- Saturated overflow: accept result=16'h7FFF, ovfl=1, mask=111 -> flags=3'b010; then accept 0x8000, ovfl=0, mask=001 -> flags=3'b011 (Z, V held; N set).
- Backpressure: out_ready=0, three back-to-back valid inputs 0x0001, 0x0002, 0x0003 -> in_ready drops after the 2nd accept and the 3rd is held. Raise out_ready -> outputs 0x0001, 0x0002, 0x0003 in order with no loss or duplication.
- mem_op bypass: flags=3'b010; accept result=0x0000, mem_op=1, mask=111 -> flags unchanged at 3'b010; out_mem_op=1.
- Flush collision: occupancy 2, assert flush with in_valid=1, result=0x0000, mask=111 -> occupancy 0 next cycle, flags unchanged, in_ready=1.
- Async reset mid-stream: deassert rst_n between edges while occupancy=1 -> out_valid=0 and flags=0 immediately without a clock edge. With OVFL_CNT_EN: after 3 overflow accepts, ovfl_count=3 and it is unaffected by flush.

Source files
------------

// File: rtl/ex_flag_stage_pkg.sv
// Shared definitions for the execute-stage flag/result buffer: flag bit
// indices, the flag vector type, common update masks and the flag merge rule.
package ex_flag_stage_pkg;

    localparam int DATA_W = 16;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef logic [2:0] flag_t;

    localparam flag_t MASK_ALL  = 3'b111;
    localparam flag_t MASK_NONE = 3'b000;
    localparam flag_t MASK_ZN   = 3'b101;

    // Enabled bits take the freshly computed value, the rest keep the old one.
    function automatic flag_t merge_flags(
        flag_t cur,
        flag_t mask,
        logic  z,
        logic  v,
        logic  n
    );
        flag_t upd;
        upd         = MASK_NONE;
        upd[FLAG_Z] = z;
        upd[FLAG_V] = v;
        upd[FLAG_N] = n;
        return (cur & ~mask) | (upd & mask);
    endfunction

endpackage

// File: rtl/ex_flag_stage_elastic_buf2.sv
// Generic 2-entry valid/ready FIFO with synchronous flush. in_ready depends
// only on the registered occupancy, never combinationally on out_ready.
module ex_flag_stage_elastic_buf2 #(
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both slots are reset so the head reads zero after reset; with two entries this is cheap.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            // A head issued in this cycle is already delivered; everything else is dropped.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values of the others.
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-stage result buffer and {Z,V,N} flag register. Optional overflow
// event counter is built when OVFL_CNT_EN is defined.
module ex_flag_stage
    import ex_flag_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W
`ifdef OVFL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_ovfl,
    input  logic             in_mem_op,
    input  logic [2:0]       in_flag_mask,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_mem_op,
    output logic [2:0]       flags
`ifdef OVFL_CNT_EN
    ,
    output logic [CNT_W-1:0] ovfl_count
`endif
);

    logic         accept;
    logic         flag_write;
    logic [WIDTH:0] head;
    flag_t        flags_q;

    ex_flag_stage_elastic_buf2 #(
        .DW (WIDTH + 1)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_result, in_mem_op}),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_result = head[WIDTH:1];
    assign out_mem_op = head[0];

    // Flush beats a simultaneous accept, so a dropped entry never touches the flags.
    assign accept     = in_valid & in_ready & ~flush;
    assign flag_write = accept & ~in_mem_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= MASK_NONE;
        end else if (flag_write) begin
            flags_q <= merge_flags(flags_q, in_flag_mask,
                                   (in_result == '0), in_ovfl, in_result[WIDTH-1]);
        end
    end

    assign flags = flags_q;

`ifdef OVFL_CNT_EN
    // Saturating count of flag-visible overflows; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfl_count <= '0;
        end else if (flag_write && in_ovfl && (ovfl_count != '1)) begin
            ovfl_count <= ovfl_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_flag_stage.sv
// Scoreboard bench for ex_flag_stage: directed scenarios then randomized traffic,
// checked against a queue-based reference model.
module tb_ex_flag_stage;
    import ex_flag_stage_pkg::*;

    localparam int W  = DATA_W;
    localparam int CW = 16;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          in_valid     = 1'b0;
    logic          in_ovfl      = 1'b0;
    logic          in_mem_op    = 1'b0;
    logic          flush        = 1'b0;
    logic          out_ready    = 1'b0;
    logic [W-1:0]  in_result    = '0;
    logic [2:0]    in_flag_mask = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_mem_op;
    logic [W-1:0]  out_result;
    logic [2:0]    flags;
`ifdef OVFL_CNT_EN
    logic [CW-1:0] ovfl_count;
`endif

    ex_flag_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_ovfl      (in_ovfl),
        .in_mem_op    (in_mem_op),
        .in_flag_mask (in_flag_mask),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_mem_op   (out_mem_op),
        .flags        (flags)
`ifdef OVFL_CNT_EN
        ,
        .ovfl_count   (ovfl_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue of delivered-in-order items,
    // flags follow the most recently accepted non-memory instruction.
    typedef struct {
        logic [W-1:0] result;
        logic         mem_op;
    } item_t;

    item_t      exp_q[$];
    item_t      head_item;
    int         m_occ   = 0;
    logic [2:0] m_flags = 3'b000;
    int         m_cnt   = 0;
    logic       m_acc;
    logic       m_iss;
    logic       rand_ready = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_occ   = 0;
                m_flags = 3'b000;
                m_cnt   = 0;
                exp_q.delete();
            end else begin
                m_acc = in_valid && (m_occ < 2) && !flush;
                m_iss = (m_occ > 0) && out_ready;
                if (m_acc && !in_mem_op) begin
                    if (in_flag_mask[2]) m_flags[2] = (in_result == 0);
                    if (in_flag_mask[1]) m_flags[1] = in_ovfl;
                    if (in_flag_mask[0]) m_flags[0] = in_result[W-1];
                    if (in_ovfl && m_cnt < (2**CW - 1)) m_cnt++;
                end
                if (flush) begin
                    m_occ = 0;
                    exp_q.delete();
                end else begin
                    m_occ = m_occ + int'(m_acc) - int'(m_iss);
                    if (m_acc) exp_q.push_back(item_t'{result: in_result, mem_op: in_mem_op});
                end
            end
        end
    end

    // Monitor: samples on the falling edge and pops the scoreboard on each delivery.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready", in_ready, m_occ < 2);
                check("out_valid", out_valid, m_occ > 0);
                check("flags", flags, m_flags);
`ifdef OVFL_CNT_EN
                check("ovfl_count", ovfl_count, m_cnt);
`endif
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL out_unexpected: got result 0x%0h, expected no delivery at %0t",
                                 out_result, $time);
                    end else begin
                        head_item = exp_q.pop_front();
                        check("out_result", out_result, head_item.result);
                        check("out_mem_op", out_mem_op, head_item.mem_op);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] r, input logic ov, input logic mem, input logic [2:0] m);
        int waited = 0;
        in_valid     = 1'b1;
        in_result    = r;
        in_ovfl      = ov;
        in_mem_op    = mem;
        in_flag_mask = m;
        flush        = 1'b0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready 0 for %0d cycles, expected 1", waited);
        end
        tick();
        in_valid = 1'b0;
    endtask

    int         base;
    logic [W-1:0] rr;

    initial begin
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_result", out_result, 0);
        check("rst_out_mem_op", out_mem_op, 0);
        check("rst_flags", flags, 3'b000);

        // Basic flag update and one-cycle latency
        out_ready = 1'b1;
        send(16'h0000, 1'b0, 1'b0, MASK_ALL);
        check("basic_flags", flags, 3'b100);
        check("basic_out_valid", out_valid, 1);
        check("basic_out_result", out_result, 16'h0000);

        // Saturated overflow, then N-only update
        send(16'h7FFF, 1'b1, 1'b0, MASK_ALL);
        check("sat_flags", flags, 3'b010);
        send(16'h8000, 1'b0, 1'b0, 3'b001);
        check("nonly_flags", flags, 3'b011);

        // mem_op never touches flags
        send(16'h1234, 1'b1, 1'b0, MASK_ALL);
        check("pre_mem_flags", flags, 3'b010);
        send(16'h0000, 1'b0, 1'b1, MASK_ALL);
        check("mem_flags", flags, 3'b010);
        check("mem_out_mem_op", out_mem_op, 1);
        tick();

        // Backpressure: three back-to-back inputs, third held while full
        out_ready    = 1'b0;
        tick();
        base         = n_out;
        in_valid     = 1'b1;
        in_mem_op    = 1'b0;
        in_ovfl      = 1'b0;
        in_flag_mask = MASK_NONE;
        in_result    = 16'h0001;
        tick();
        in_result    = 16'h0002;
        tick();
        check("bp_full_in_ready", in_ready, 0);
        in_result    = 16'h0003;
        tick();
        tick();
        check("bp_held_in_ready", in_ready, 0);
        check("bp_head", out_result, 16'h0001);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bp_drained", out_valid, 0);
        check("bp_delivered", n_out - base, 3);

        // Flush collides with an accept while full
        out_ready = 1'b0;
        send(16'h8001, 1'b1, 1'b0, MASK_ALL);
        send(16'h0005, 1'b0, 1'b0, MASK_NONE);
        check("fl_pre_flags", flags, 3'b011);
        check("fl_pre_in_ready", in_ready, 0);
        flush        = 1'b1;
        in_valid     = 1'b1;
        in_result    = 16'h0000;
        in_ovfl      = 1'b0;
        in_flag_mask = MASK_ALL;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_flags", flags, 3'b011);
        tick();

        // Asynchronous reset between edges with one entry buffered
        send(16'h8000, 1'b0, 1'b0, MASK_ALL);
        check("ar_pre_flags", flags, 3'b001);
        check("ar_pre_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_flags", flags, 3'b000);
        check("ar_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();

`ifdef OVFL_CNT_EN
        out_ready = 1'b1;
        send(16'h7FFF, 1'b1, 1'b0, MASK_NONE);
        send(16'h8000, 1'b1, 1'b1, MASK_ALL);
        send(16'h8000, 1'b1, 1'b0, MASK_ZN);
        send(16'h7FFF, 1'b1, 1'b0, MASK_ALL);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("cnt_after_flush", ovfl_count, 3);
`endif

        // Randomized traffic with random backpressure and occasional flushes
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0: begin
                    flush        = 1'b1;
                    in_valid     = 1'($urandom_range(0, 1));
                    in_result    = W'($urandom);
                    in_ovfl      = 1'($urandom_range(0, 1));
                    in_flag_mask = 3'($urandom_range(0, 7));
                    tick();
                    flush    = 1'b0;
                    in_valid = 1'b0;
                end
                1, 2: tick();
                default: begin
                    case ($urandom_range(0, 3))
                        0:       rr = 16'h0000;
                        1:       rr = 16'h7FFF;
                        2:       rr = 16'h8000;
                        default: rr = W'($urandom);
                    endcase
                    send(rr, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                         3'($urandom_range(0, 7)));
                end
            endcase
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (4) tick();
        check("final_drained", exp_q.size(), 0);
        check("final_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
